// File: rtl/mito_pkg.sv
// ----------------------------------------------------------------------------
// mito_pkg
// Shared definitions for the OFM accumulation / pooling datapath.
//   - Default datapath widths.
//   - Frame-control FSM state type.
//   - sat_shift(): round-half-up arithmetic right shift followed by signed
//     saturation (optionally clamping negatives to zero). The function works
//     on a 64-bit container so callers of any width up to 64 bits can use it
//     and then truncate the result to their output width.
// ----------------------------------------------------------------------------
package mito_pkg;

    localparam int MITO_IN_WIDTH  = 20;
    localparam int MITO_ACC_WIDTH = 32;
    localparam int MITO_OUT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Round (add half an LSB of the result), arithmetic shift, saturate to
    // out_w signed bits. With relu set, negative results are clamped to zero
    // before saturation.
    function automatic logic signed [63:0] sat_shift(
        input logic signed [63:0] val,
        input int unsigned        shift,
        input int unsigned        out_w,
        input logic               relu
    );
        logic signed [63:0] rnd;
        logic signed [63:0] r;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        if (shift > 32'd0) begin
            rnd = 64'sd1 <<< (shift - 32'd1);
        end else begin
            rnd = 64'sd0;
        end
        r = (val + rnd) >>> shift;
        if (relu && (r < 64'sd0)) begin
            r = 64'sd0;
        end else begin
            r = r;
        end
        max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 32'd1));
        if (r > max_v) begin
            sat_shift = max_v;
        end else if (r < min_v) begin
            sat_shift = min_v;
        end else begin
            sat_shift = r;
        end
    endfunction

endpackage

// File: rtl/ofm_fifo.sv
// ----------------------------------------------------------------------------
// ofm_fifo
// Synchronous FIFO with occupancy count. DEPTH must be a power of two so the
// pointers wrap naturally. Storage is cleared on reset so the head output
// reads zero while empty after reset.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, push_data write side (a push when full is dropped unless a pop
//                   happens on the same edge)
//   pop             read side (ignored when empty)
//   head_data       current head entry
//   valid           registered not-empty flag
//   count           number of stored entries (0..DEPTH)
// ----------------------------------------------------------------------------
module ofm_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             valid_r;
    logic             pop_ok_s;
    logic             push_ok_s;
    logic [CW-1:0]    count_nxt_s;

    assign pop_ok_s  = pop && valid_r;
    assign push_ok_s = push && ((count_r != CW'(DEPTH)) || pop_ok_s);

    // Next occupancy from the push/pop combination.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CW'(1'b1);
            2'b01:   count_nxt_s = count_r - CW'(1'b1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {CW{1'b0}});
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign valid     = valid_r;
    assign count     = count_r;

endmodule

// File: rtl/ofm_accumulator.sv
// ----------------------------------------------------------------------------
// ofm_accumulator
// Accumulates NUM_CH per-channel window sums per output pixel, requantizes
// each pixel sum (rounding shift + saturation) and buffers the OFM bytes in a
// small FIFO. A start/done FSM frames one feature map of NUM_PIX pixels.
//
// Optional feature: define OFM_RELU_EN to clamp negative requantized values
// to zero (output range [0, 2^(OUT_WIDTH-1)-1]); latency is unchanged.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               begins a frame when idle, ignored otherwise
//   busy                high while running or draining
//   done                one-cycle pulse once the frame is fully drained
//   psum_valid/ready    partial-sum input handshake, psum_in data
//   ofm_valid/ready     OFM output handshake, ofm_data data
//
// Pipeline: stage 1 is the accumulator (s1_sum/s1_valid capture a finished
// pixel), stage 2 requantizes s1_sum and pushes it into the FIFO.
// ----------------------------------------------------------------------------
module ofm_accumulator
    import mito_pkg::*;
#(
    parameter int IN_WIDTH   = MITO_IN_WIDTH,
    parameter int ACC_WIDTH  = MITO_ACC_WIDTH,
    parameter int OUT_WIDTH  = MITO_OUT_WIDTH,
    parameter int NUM_CH     = 16,
    parameter int NUM_PIX    = 784,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    input  logic                        psum_valid,
    output logic                        psum_ready,
    input  logic signed [IN_WIDTH-1:0]  psum_in,
    output logic                        ofm_valid,
    input  logic                        ofm_ready,
    output logic signed [OUT_WIDTH-1:0] ofm_data
);

    localparam int CH_W  = (NUM_CH  > 1) ? $clog2(NUM_CH)  : 1;
    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef OFM_RELU_EN
    localparam logic RELU = 1'b1;
`else
    localparam logic RELU = 1'b0;
`endif

    state_t                       state_r;
    logic signed [ACC_WIDTH-1:0]  acc_r;
    logic [CH_W-1:0]              ch_cnt_r;
    logic [PIX_W-1:0]             pix_cnt_r;
    logic signed [ACC_WIDTH-1:0]  s1_sum_r;
    logic                         s1_valid_r;
    logic                         done_r;

    logic signed [ACC_WIDTH-1:0]  psum_ext_s;
    logic signed [ACC_WIDTH-1:0]  acc_sum_s;
    logic                         ready_s;
    logic                         accept_s;
    logic                         last_ch_s;
    logic                         last_pix_s;
    logic [OUT_WIDTH-1:0]         push_data_s;
    logic [OUT_WIDTH-1:0]         head_data_s;
    logic                         fifo_valid_s;
    logic [CNT_W-1:0]             fifo_count_s;

    // Size cast of a signed operand sign-extends.
    assign psum_ext_s = ACC_WIDTH'(psum_in);
    assign acc_sum_s  = acc_r + psum_ext_s;
    assign last_ch_s  = (ch_cnt_r == CH_W'(NUM_CH - 1));
    assign last_pix_s = (pix_cnt_r == PIX_W'(NUM_PIX - 1));
    assign accept_s   = psum_valid && ready_s;

    // Input may only be accepted when the FIFO plus the stage-1 register
    // still leaves room, so a stage-2 push never finds the FIFO full.
    always_comb begin
        ready_s = 1'b0;
        case (state_r)
            RUN: begin
                ready_s = (({1'b0, fifo_count_s} + {{CNT_W{1'b0}}, s1_valid_r})
                           < (CNT_W + 1)'(FIFO_DEPTH));
            end
            default: ready_s = 1'b0;
        endcase
    end

    // Frame FSM, accumulator, pixel/channel counters and stage-1 register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            acc_r      <= {ACC_WIDTH{1'b0}};
            ch_cnt_r   <= {CH_W{1'b0}};
            pix_cnt_r  <= {PIX_W{1'b0}};
            s1_sum_r   <= {ACC_WIDTH{1'b0}};
            s1_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r     <= 1'b0;
            // Stage 1 drains into stage 2 every cycle; it only stays set
            // when a new pixel completes on this edge.
            s1_valid_r <= accept_s && last_ch_s;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= RUN;
                        acc_r     <= {ACC_WIDTH{1'b0}};
                        ch_cnt_r  <= {CH_W{1'b0}};
                        pix_cnt_r <= {PIX_W{1'b0}};
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        if (last_ch_s) begin
                            s1_sum_r <= acc_sum_s;
                            acc_r    <= {ACC_WIDTH{1'b0}};
                            ch_cnt_r <= {CH_W{1'b0}};
                            if (last_pix_s) begin
                                pix_cnt_r <= {PIX_W{1'b0}};
                                state_r   <= DRAIN;
                            end else begin
                                pix_cnt_r <= pix_cnt_r + PIX_W'(1'b1);
                            end
                        end else begin
                            acc_r    <= acc_sum_s;
                            ch_cnt_r <= ch_cnt_r + CH_W'(1'b1);
                        end
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                DRAIN: begin
                    if (!s1_valid_r && !fifo_valid_s) begin
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Stage 2: requantize the captured pixel sum.
    assign push_data_s = OUT_WIDTH'(sat_shift(64'(s1_sum_r), SHIFT, OUT_WIDTH, RELU));

    ofm_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (s1_valid_r),
        .push_data (push_data_s),
        .pop       (ofm_ready),
        .head_data (head_data_s),
        .valid     (fifo_valid_s),
        .count     (fifo_count_s)
    );

    assign busy       = (state_r == RUN) || (state_r == DRAIN);
    assign done       = done_r;
    assign psum_ready = ready_s;
    assign ofm_valid  = fifo_valid_s;
    assign ofm_data   = head_data_s;

endmodule

// File: doc/ofm_accumulator.md
Name: ofm_accumulator

Overview:
- Sits directly downstream of the 3x3 adder-tree stage.
- Per output pixel, it accumulates NUM_CH per-channel window sums (bias already folded in by the tree) into a wide accumulator.
- It then requantizes the sum (rounding shift plus saturation) and buffers the 8-bit OFM values in a small FIFO for the OFM writer.
- A start/done FSM frames one output feature map of NUM_PIX pixels.

Parameters:
- IN_WIDTH, 20, signed partial-sum width from the adder tree
- ACC_WIDTH, 32, signed accumulator width; must be >= IN_WIDTH + clog2(NUM_CH)
- OUT_WIDTH, 8, signed OFM output width
- NUM_CH, 16, partial sums per output pixel (>= 1)
- NUM_PIX, 784, output pixels per frame (>= 1)
- SHIFT, 8, requantization right-shift (0..ACC_WIDTH-1)
- FIFO_DEPTH, 4, output FIFO entries (power of 2, >= 2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a frame when IDLE, ignored otherwise
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse when frame fully drained
- psum_valid  in  1  partial sum valid
- psum_ready  out  1  block can accept a partial sum
- psum_in  in  IN_WIDTH  signed partial sum
- ofm_valid  out  1  FIFO head valid
- ofm_ready  in  1  consumer accepts the head
- ofm_data  out  OUT_WIDTH  signed requantized OFM value

Behaviour:
- Reset:
  - rst sampled at posedge; it clears all state regardless of the current state, including mid-frame.
  - Reset values: state=IDLE, acc=0, ch_cnt=0, pix_cnt=0, stage-1 valid=0, FIFO empty.
  - Output reset values: busy=0, done=0, psum_ready=0, ofm_valid=0, ofm_data=0.
- Handshakes:
  - A transfer occurs on any edge where valid && ready.
  - psum_valid may assert without waiting for psum_ready.
  - ofm_data/ofm_valid are held stable until accepted.
- FSM states:
  - IDLE: psum_ready=0. On start, go to RUN and clear ch_cnt and pix_cnt.
  - RUN: psum_ready = (fifo_count + s1_valid) < FIFO_DEPTH.
    - Each accepted psum sets acc <= acc + sign-extended psum_in and ch_cnt++.
    - On the accept with ch_cnt==NUM_CH-1:
      - s1_sum <= acc + psum_in and s1_valid <= 1.
      - acc <= 0, ch_cnt <= 0, pix_cnt++.
      - If pix_cnt==NUM_PIX-1, go to DRAIN.
  - DRAIN: psum_ready=0. When s1_valid==0 and the FIFO is empty (after the final pop), pulse done for one cycle and go to IDLE.
- Stage 2 (requantize, one cycle after stage 1):
  - r = (s1_sum + (SHIFT>0 ? 1<<(SHIFT-1) : 0)) >>> SHIFT (arithmetic shift).
  - Saturate r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Push into the FIFO; s1_valid clears unless it is refilled on the same edge.
- Latency: accept of the last psum of a pixel at edge N puts the result at the FIFO head by edge N+2 (ofm_valid high in cycle N+2) if the FIFO was empty.
- Accumulator arithmetic:
  - Two's complement, no overflow detection.
  - Overflow is prevented by the ACC_WIDTH parameter constraint.
- FIFO:
  - Simultaneous push and pop when full is legal; psum_ready gating guarantees a push never finds the FIFO full.
  - Pop when empty cannot occur, since ofm_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- NUM_CH==1: every accepted psum completes a pixel.
- start while busy: ignored, with no effect on counters.

Optional Feature:
- Macro: OFM_RELU_EN.
- Defined: stage 2 clamps negative r to 0 before saturation, so the output range is [0, 2^(OUT_WIDTH-1)-1].
- Undefined: full signed saturation as above.
- Identical latency either way.

Decomposition:
- Shared package mito_pkg holds:
  - Default width constants (IN_WIDTH, ACC_WIDTH, OUT_WIDTH).
  - The FSM state typedef: enum IDLE/RUN/DRAIN.
  - A sat_shift function (round, shift, saturate), reused by later pooling stages.
- One natural sub-module: ofm_fifo, a synchronous FIFO parameterized by width and depth, with count output.

Test Plan:
1. NUM_CH=4, NUM_PIX=1, SHIFT=2, ofm_ready=1; psums 10, 20, 30, 41 -> one output 25 (101+2=103 >>> 2 = 25); done pulses after the pop; busy then falls.
2. NUM_CH=2, SHIFT=0; psums 100, 200 -> 127 (saturated); psums -300, 0 -> -128 without OFM_RELU_EN, 0 with it.
3. FIFO_DEPTH=4, NUM_CH=1, ofm_ready=0; stream 8 psums -> psum_ready drops after 4 accepts; no data loss; raise ofm_ready -> all 8 outputs in order.
4. Assert rst mid-pixel (ch_cnt=2) -> next cycle psum_ready=0, ofm_valid=0, busy=0; a new start then produces a correct first pixel.
5. start pulsed during RUN and psum_valid held in IDLE -> no accept, no counter change.
6. Random psum_valid/ofm_ready toggling over NUM_PIX=16, NUM_CH=3 -> outputs match the reference model bit-exactly; exactly one done pulse.
